// File: rtl/player_mover.sv
// player_mover: moves an 8x8 sprite on a 96x64 OLED one pixel per three
// movement ticks, tracking a decrementing energy budget.
// velocity_clk is asynchronous to sysclk; each of its toggles becomes a
// single-cycle tick after a two-flop synchroniser and an edge detector.
module player_mover #(
    parameter int START_X    = 44,
    parameter int START_Y    = 28,
    parameter int MAX_X      = 88,
    parameter int MAX_Y      = 56,
    parameter int ENERGY_MAX = 1000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        en,
    input  logic        velocity_clk,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        energy_refill,
    output logic [6:0]  pos_x,
    output logic [5:0]  pos_y,
    output logic [10:0] energy,
    output logic        moving,
    output logic        step_done,
    output logic        blocked
);

    typedef enum logic [1:0] {IDLE, PH1, PH2} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic signed [8:0] MAX_X_S = 9'(MAX_X);
    localparam logic signed [8:0] MAX_Y_S = 9'(MAX_Y);

    state_t state;
    dir_t   dir;

    // velocity_clk synchroniser (p0, p1) and edge history (p2)
    logic vclk_p0, vclk_p1, vclk_p2;
    logic tick;

    logic signed [8:0] dx, dy;
    logic signed [8:0] cur_x, cur_y;
    logic signed [8:0] nx, ny;
    logic              move_ok;

    // Coordinate offset kept signed so a step off the top/left edge goes negative
    function automatic logic signed [8:0] offset_coord(input logic signed [8:0] coord,
                                                       input logic signed [8:0] delta);
        return coord + delta;
    endfunction

    function automatic logic in_bounds(input logic signed [8:0] coord,
                                       input logic signed [8:0] limit);
        return (coord >= 9'sd0) && (coord <= limit);
    endfunction

    // Energy never wraps below zero; movement remains legal at zero
    function automatic logic [10:0] energy_dec_sat(input logic [10:0] e);
        return (e == 11'd0) ? 11'd0 : e - 11'd1;
    endfunction

    // Bring velocity_clk into the sysclk domain and keep one cycle of history
    always_ff @(posedge sysclk) begin
        if (reset) begin
            vclk_p0 <= 1'b0;
            vclk_p1 <= 1'b0;
            vclk_p2 <= 1'b0;
        end else begin
            vclk_p0 <= velocity_clk;
            vclk_p1 <= vclk_p0;
            vclk_p2 <= vclk_p1;
        end
    end

    // Either edge of the synchronised clock yields a one-cycle tick
    assign tick = vclk_p1 ^ vclk_p2;

    // Candidate position for the latched direction and its legality
    always_comb begin
        dx = 9'sd0;
        dy = 9'sd0;
        case (dir)
            DIR_UP:    dy = -9'sd1;
            DIR_DOWN:  dy = 9'sd1;
            DIR_LEFT:  dx = -9'sd1;
            DIR_RIGHT: dx = 9'sd1;
            default:   dx = 9'sd0;
        endcase
        cur_x   = $signed({2'b00, pos_x});
        cur_y   = $signed({3'b000, pos_y});
        nx      = offset_coord(cur_x, dx);
        ny      = offset_coord(cur_y, dy);
        move_ok = in_bounds(nx, MAX_X_S) && in_bounds(ny, MAX_Y_S);
    end

    // Three-phase step FSM with position, energy and pulse outputs registered
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= DIR_RIGHT;
            pos_x     <= 7'(START_X);
            pos_y     <= 6'(START_Y);
            energy    <= 11'(ENERGY_MAX);
            moving    <= 1'b0;
            step_done <= 1'b0;
            blocked   <= 1'b0;
        end else begin
            step_done <= 1'b0;
            blocked   <= 1'b0;
            if (en && tick) begin
                case (state)
                    IDLE: begin
                        if (btn_up || btn_down || btn_left || btn_right) begin
                            if (btn_up)        dir <= DIR_UP;
                            else if (btn_down) dir <= DIR_DOWN;
                            else if (btn_left) dir <= DIR_LEFT;
                            else               dir <= DIR_RIGHT;
                            state  <= PH1;
                            moving <= 1'b1;
                        end
                    end
                    PH1: begin
                        state  <= PH2;
                        moving <= 1'b1;
                    end
                    PH2: begin
                        state  <= IDLE;
                        moving <= 1'b0;
                        if (move_ok) begin
                            pos_x     <= nx[6:0];
                            pos_y     <= ny[5:0];
                            energy    <= energy_dec_sat(energy);
                            step_done <= 1'b1;
                        end else begin
                            blocked <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        moving <= 1'b0;
                    end
                endcase
            end
            // A refill wins over a same-cycle commit decrement and ignores en
            if (energy_refill) begin
                energy <= 11'(ENERGY_MAX);
            end
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// Testbench for player_mover: table-driven scenarios from reset, hand-written
// multi-cycle sequences, and randomized stimulus against a tick-queue model.
module tb_player_mover;

    logic        sysclk = 1'b0;
    logic        reset, en, velocity_clk;
    logic        btn_up, btn_down, btn_left, btn_right, energy_refill;
    logic [6:0]  pos_x;
    logic [5:0]  pos_y;
    logic [10:0] energy;
    logic        moving, step_done, blocked;

    player_mover dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .en            (en),
        .velocity_clk  (velocity_clk),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .energy_refill (energy_refill),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .energy        (energy),
        .moving        (moving),
        .step_done     (step_done),
        .blocked       (blocked)
    );

    always #5 sysclk = ~sysclk;

    int npass  = 0;
    int ntotal = 0;
    int ecount = 0;
    int due[$];
    int nsteps, nblocks;

    // Reference model: a move is a count of three accepted ticks
    int   m_x, m_y, m_e, m_count, m_dir;
    logic m_sd, m_blk;

    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    typedef struct {
        logic [3:0] btn;
        int         toggles;
        int         ex, ey, ee, esteps, eblocks;
    } vec_t;
    vec_t vecs[11];

    task automatic set_btn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic check(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic model_edge(input logic r, input logic e_n, input logic [3:0] b, input logic rf);
        logic tick;
        int   tx, ty;
        tick = 1'b0;
        while (due.size() > 0 && due[0] <= ecount) begin
            if (due[0] == ecount) tick = 1'b1;
            void'(due.pop_front());
        end
        m_sd  = 1'b0;
        m_blk = 1'b0;
        if (r) begin
            m_x = 44; m_y = 28; m_e = 1000; m_count = 0; m_dir = 0;
            due.delete();
        end else begin
            if (tick && e_n) begin
                if (m_count == 0) begin
                    if (b != 4'b0000) begin
                        m_dir   = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
                        m_count = 1;
                    end
                end else if (m_count == 1) begin
                    m_count = 2;
                end else begin
                    m_count = 0;
                    tx = m_x + ((m_dir == 3) ? 1 : (m_dir == 2) ? -1 : 0);
                    ty = m_y + ((m_dir == 1) ? 1 : (m_dir == 0) ? -1 : 0);
                    if (tx >= 0 && tx <= 88 && ty >= 0 && ty <= 56) begin
                        m_x  = tx;
                        m_y  = ty;
                        m_e  = (m_e > 0) ? m_e - 1 : 0;
                        m_sd = 1'b1;
                    end else begin
                        m_blk = 1'b1;
                    end
                end
            end
            if (rf) m_e = 1000;
        end
    endtask

    task automatic cyc();
        logic r, e_n, rf;
        logic [3:0] b;
        r   = reset;
        e_n = en;
        rf  = energy_refill;
        b   = {btn_up, btn_down, btn_left, btn_right};
        @(posedge sysclk);
        #1;
        ecount++;
        model_edge(r, e_n, b, rf);
        ntotal++;
        if (int'(pos_x) == m_x && int'(pos_y) == m_y && int'(energy) == m_e &&
            moving == (m_count != 0) && step_done == m_sd && blocked == m_blk)
            npass++;
        else
            $display("FAIL cycle%0d: actual x=%0d y=%0d e=%0d mv=%0d sd=%0d bk=%0d required x=%0d y=%0d e=%0d mv=%0d sd=%0d bk=%0d",
                     ecount, pos_x, pos_y, energy, moving, step_done, blocked,
                     m_x, m_y, m_e, (m_count != 0), m_sd, m_blk);
        if (step_done) nsteps++;
        if (blocked)   nblocks++;
    endtask

    task automatic toggle_vc();
        velocity_clk = ~velocity_clk;
        due.push_back(ecount + 3);
    endtask

    task automatic tick_wait();
        toggle_vc();
        repeat (4) cyc();
    endtask

    task automatic do_reset();
        set_btn(B_NONE);
        if (velocity_clk) tick_wait();
        reset = 1'b1;
        cyc();
        cyc();
        reset   = 1'b0;
        nsteps  = 0;
        nblocks = 0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; velocity_clk = 1'b0; energy_refill = 1'b0;
        set_btn(B_NONE);
        m_x = 44; m_y = 28; m_e = 1000; m_count = 0; m_dir = 0; m_sd = 0; m_blk = 0;
        nsteps = 0; nblocks = 0;

        vecs[0]  = '{B_RIGHT,          3,  45, 28, 999,  1, 0};
        vecs[1]  = '{B_UP | B_LEFT,    6,  44, 26, 998,  2, 0};
        vecs[2]  = '{B_DOWN,           3,  44, 29, 999,  1, 0};
        vecs[3]  = '{B_LEFT,           6,  42, 28, 998,  2, 0};
        vecs[4]  = '{B_NONE,           6,  44, 28, 1000, 0, 0};
        vecs[5]  = '{4'b0111,          3,  44, 29, 999,  1, 0};
        vecs[6]  = '{B_LEFT | B_RIGHT, 3,  43, 28, 999,  1, 0};
        vecs[7]  = '{B_RIGHT,          2,  44, 28, 1000, 0, 0};
        vecs[8]  = '{B_UP,             87, 44, 0,  972,  28, 1};
        vecs[9]  = '{B_RIGHT,          135, 88, 28, 956, 44, 1};
        vecs[10] = '{B_DOWN,           87, 44, 56, 972,  28, 1};

        // Reset state
        do_reset();
        check("rst_x", pos_x, 44);
        check("rst_y", pos_y, 28);
        check("rst_energy", energy, 1000);
        check("rst_moving", moving, 0);
        check("rst_step_done", step_done, 0);
        check("rst_blocked", blocked, 0);

        // Table of scenarios, each from a fresh reset
        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_btn(vecs[i].btn);
            for (int t = 0; t < vecs[i].toggles; t++) tick_wait();
            set_btn(B_NONE);
            cyc();
            check($sformatf("vec%0d_x", i), pos_x, vecs[i].ex);
            check($sformatf("vec%0d_y", i), pos_y, vecs[i].ey);
            check($sformatf("vec%0d_energy", i), energy, vecs[i].ee);
            check($sformatf("vec%0d_steps", i), nsteps, vecs[i].esteps);
            check($sformatf("vec%0d_blocks", i), nblocks, vecs[i].eblocks);
        end

        // Commit lands exactly three edges after the third toggle
        do_reset();
        set_btn(B_RIGHT);
        tick_wait();
        check("lat_moving_ph1", moving, 1);
        tick_wait();
        toggle_vc();
        cyc();
        cyc();
        check("lat_x_before", pos_x, 44);
        check("lat_sd_before", step_done, 0);
        cyc();
        check("lat_x_commit", pos_x, 45);
        check("lat_sd_commit", step_done, 1);
        check("lat_energy_commit", energy, 999);
        check("lat_moving_commit", moving, 0);
        cyc();
        check("lat_sd_after", step_done, 0);

        // Direction latched on the first tick survives button release
        do_reset();
        set_btn(B_DOWN);
        tick_wait();
        check("rel_moving1", moving, 1);
        set_btn(B_NONE);
        tick_wait();
        check("rel_moving2", moving, 1);
        tick_wait();
        check("rel_y", pos_y, 29);
        check("rel_moving_idle", moving, 0);

        // Refill coinciding with a commit: energy restored, position still moves
        do_reset();
        set_btn(B_RIGHT);
        repeat (3) tick_wait();
        check("refill_pre_energy", energy, 999);
        tick_wait();
        tick_wait();
        toggle_vc();
        cyc();
        cyc();
        energy_refill = 1'b1;
        cyc();
        energy_refill = 1'b0;
        check("refill_commit_energy", energy, 1000);
        check("refill_commit_x", pos_x, 46);
        check("refill_commit_sd", step_done, 1);
        repeat (3) tick_wait();
        check("refill_en_low_pre", energy, 999);
        en = 1'b0;
        energy_refill = 1'b1;
        cyc();
        energy_refill = 1'b0;
        check("refill_en_low", energy, 1000);
        en = 1'b1;

        // Reset during PH2 abandons the step; ticks while en is low are dropped
        do_reset();
        set_btn(B_DOWN);
        tick_wait();
        tick_wait();
        check("ph2_moving", moving, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("ph2_rst_x", pos_x, 44);
        check("ph2_rst_y", pos_y, 28);
        check("ph2_rst_energy", energy, 1000);
        check("ph2_rst_moving", moving, 0);
        en = 1'b0;
        repeat (5) tick_wait();
        check("enlow_y", pos_y, 28);
        check("enlow_moving", moving, 0);
        en = 1'b1;
        repeat (6) cyc();
        check("enhigh_moving", moving, 0);
        check("enhigh_y", pos_y, 28);
        set_btn(B_NONE);

        // Drain energy to zero and confirm movement still works
        do_reset();
        for (int s = 0; s < 1000; s++) begin
            set_btn((s % 2 == 0) ? B_RIGHT : B_LEFT);
            repeat (3) begin
                toggle_vc();
                cyc();
            end
            repeat (3) cyc();
        end
        check("drain_energy", energy, 0);
        check("drain_x", pos_x, 44);
        set_btn(B_RIGHT);
        repeat (3) tick_wait();
        check("zero_move_x", pos_x, 45);
        check("zero_move_energy", energy, 0);
        check("zero_move_steps", nsteps, 1001);

        // Randomized stimulus checked cycle by cycle against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_btn(4'($urandom_range(0, 15)));
            en            = ($urandom_range(0, 7) != 0);
            energy_refill = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) toggle_vc();
            cyc();
        end
        energy_refill = 1'b0;
        en = 1'b1;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 SHALL have parameter START_X, default 44, reset x position (pixels).
REQ-002 SHALL have parameter START_Y, default 28, reset y position (pixels).
REQ-003 SHALL have parameter MAX_X, default 88, largest legal x (96-pixel OLED minus 8-pixel sprite).
REQ-004 SHALL have parameter MAX_Y, default 56, largest legal y (64-pixel OLED minus 8-pixel sprite).
REQ-005 SHALL have parameter ENERGY_MAX, default 1000, reset/refill energy value.
REQ-006 SHALL have port sysclk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port en  input  1  high: FSM advances; low: FSM and outputs hold.
REQ-009 SHALL have port velocity_clk  input  1  toggling speed clock; each toggle (either edge) is one movement tick.
REQ-010 SHALL have ports btn_up, btn_down, btn_left, btn_right  input  1 each  level-held direction requests.
REQ-011 SHALL have port energy_refill  input  1  single-cycle pulse restoring energy.
REQ-012 SHALL have port pos_x  output  7  sprite x, range 0..MAX_X.
REQ-013 SHALL have port pos_y  output  6  sprite y, range 0..MAX_Y; y grows downward.
REQ-014 SHALL have port energy  output  11  remaining energy, 0..ENERGY_MAX.
REQ-015 SHALL have port moving  output  1  high while FSM is in PH1 or PH2.
REQ-016 SHALL have port step_done  output  1  one-cycle pulse on a committed pixel move.
REQ-017 SHALL have port blocked  output  1  one-cycle pulse when a commit is suppressed by a wall.

Function
REQ-018 SHALL synchronise velocity_clk through two flops plus one history flop; tick = sync2 XOR history, one cycle wide per toggle, generated even when en is low.
REQ-019 SHALL act on a tick at the third sysclk rising edge after velocity_clk changes (two sync edges, then the acting edge).
REQ-020 SHALL implement FSM states IDLE, PH1, PH2; transitions occur only on a tick with en high.
REQ-021 IDLE + tick + any button held: latch direction with priority up > down > left > right, go to PH1; no button: stay IDLE.
REQ-022 PH1 + tick: go to PH2 regardless of buttons.
REQ-023 PH2 + tick: commit one-pixel move in latched direction, go to IDLE; a pixel move therefore costs exactly 3 ticks.
REQ-024 Button release or change after latching SHALL NOT affect the step in progress.
REQ-025 Commit SHALL update position, pulse step_done, and decrement energy by 1, all on the same edge.
REQ-026 Commit where the move would leave 0..MAX_X or 0..MAX_Y: position unchanged, energy unchanged, step_done low, blocked pulses instead.
REQ-027 Energy SHALL saturate at 0; movement remains allowed at energy 0.
REQ-028 energy_refill SHALL set energy to ENERGY_MAX on the next edge, overriding a same-cycle decrement, and SHALL act even when en is low.
REQ-029 en low SHALL freeze state, latched direction, position and energy (refill excepted); ticks arriving while en is low SHALL be discarded, not queued.
REQ-030 step_done and blocked SHALL never be high together and SHALL be low in every non-commit cycle.

Reset
REQ-031 With reset high at a rising edge: state IDLE, pos_x=START_X, pos_y=START_Y, energy=ENERGY_MAX, moving=0, step_done=0, blocked=0; all three sync/history flops load 0.
REQ-032 Reset mid-step (PH1/PH2) SHALL abandon the step with no position or energy change beyond the reset values.
REQ-033 Reset SHALL take priority over en, ticks and energy_refill.

Verification
REQ-034 Hold btn_right, 3 toggles of velocity_clk -> pos_x 44->45, energy 1000->999, step_done one pulse, 3 sysclk edges after third toggle.
REQ-035 Hold btn_up and btn_left together, 6 toggles -> pos_y 28->26, pos_x unchanged at 44.
REQ-036 Set pos_x=88 via repeated right steps, 3 more toggles with btn_right -> pos_x stays 88, blocked pulses, energy unchanged.
REQ-037 Press btn_down for 1 toggle then release, 2 more toggles -> pos_y 28->29, moving high for PH1/PH2 only.
REQ-038 energy_refill pulse on the same cycle as a commit -> energy=1000, position still moves.
REQ-039 Reset asserted in PH2 -> next edge pos=(44,28), energy=1000, moving=0; en low for 5 toggles -> no state change.
